// File: rtl/ids_reg_pkg.sv
// Shared types and constants for the IDS register-ring initiator.
package ids_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
  localparam logic [1:0]  DEF_SRC_ID = 2'd1;
  localparam int unsigned STALE_W    = 8;
  localparam int unsigned TIMER_W    = 16;

  localparam int unsigned DEF_ADDR_WIDTH = 23;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  function automatic logic [STALE_W-1:0] sat_inc(input logic [STALE_W-1:0] v);
    return (v == '1) ? v : v + STALE_W'(1);
  endfunction

endpackage

// File: rtl/ids_reg_timer.sv
// Load/enable counter that flags expiry in the cycle the count reaches limit.
module ids_reg_timer
  import ids_reg_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && cnt_q != '1) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of WAIT cycles already completed.
  assign expire = en && !load && (cnt_q == limit - WIDTH'(1));

endmodule

// File: rtl/ids_reg_initiator.sv
// Register-ring initiator: one host transaction at a time, issued at the ring head.
// Optional timeout enabled by defining IDS_REG_INIT_TIMEOUT_EN.
module ids_reg_initiator
  import ids_reg_pkg::*;
#(
  parameter int unsigned                  UDP_REG_SRC_WIDTH = 2,
  parameter int unsigned                  ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int unsigned                  DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = UDP_REG_SRC_WIDTH'(DEF_SRC_ID),
  parameter int unsigned                  TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         host_req,
  input  logic                         host_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]        host_addr,
  input  logic [DATA_WIDTH-1:0]        host_wdata,
  output logic                         host_busy,
  output logic                         host_done,
  output logic [DATA_WIDTH-1:0]        host_rdata,
  output logic                         host_err,
  output logic                         host_timeout,
  output logic [STALE_W-1:0]           stale_count,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [ADDR_WIDTH-1:0]        reg_addr_out,
  output logic [DATA_WIDTH-1:0]        reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [ADDR_WIDTH-1:0]        reg_addr_in,
  input  logic [DATA_WIDTH-1:0]        reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in
);

  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

  state_e                         state_q;
  logic                           rd_q;
  logic [DATA_WIDTH-1:0]          wdata_q;
  logic                           busy_q, done_q, err_q, to_q;
  logic [DATA_WIDTH-1:0]          rdata_q;
  logic [STALE_W-1:0]             stale_q;
  logic                           req_out_q, rdwr_out_q;
  logic [ADDR_WIDTH-1:0]          addr_out_q;
  logic [DATA_WIDTH-1:0]          data_out_q;
  logic [UDP_REG_SRC_WIDTH-1:0]   src_out_q;
  logic                           match, stale_hit, expire;
  logic                           unused_ring_fields;

  assign match     = (state_q == S_WAIT) && reg_req_in && (reg_src_in == SRC_ID);
  assign stale_hit = reg_req_in && !match;

  assign unused_ring_fields = ^{reg_rd_wr_L_in, reg_addr_in};

`ifdef IDS_REG_INIT_TIMEOUT_EN
  ids_reg_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == S_ISSUE),
    .en    (state_q == S_WAIT),
    .limit (TIMER_W'(TIMEOUT_CYCLES)),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
      rdata_q    <= '0;
      stale_q    <= '0;
      req_out_q  <= 1'b0;
      rdwr_out_q <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
      src_out_q  <= '0;
    end else begin
      if (stale_hit) begin
        stale_q <= sat_inc(stale_q);
      end
      // Ring head and completion flags are single-cycle unless set below.
      req_out_q  <= 1'b0;
      rdwr_out_q <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
      src_out_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host_req) begin
            rd_q       <= host_rd_wr_L;
            wdata_q    <= host_wdata;
            busy_q     <= 1'b1;
            req_out_q  <= 1'b1;
            rdwr_out_q <= host_rd_wr_L;
            addr_out_q <= host_addr;
            data_out_q <= host_rd_wr_L ? '0 : host_wdata;
            src_out_q  <= SRC_ID;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (match) begin
            done_q  <= 1'b1;
            err_q   <= !reg_ack_in;
            rdata_q <= !reg_ack_in ? ERR_WORD : (rd_q ? reg_data_in : wdata_q);
            state_q <= S_DONE;
          end else if (expire) begin
            done_q  <= 1'b1;
            to_q    <= 1'b1;
            rdata_q <= ERR_WORD;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign host_busy       = busy_q;
  assign host_done       = done_q;
  assign host_rdata      = rdata_q;
  assign host_err        = err_q;
  assign host_timeout    = to_q;
  assign stale_count     = stale_q;
  assign reg_req_out     = req_out_q;
  assign reg_ack_out     = 1'b0;
  assign reg_rd_wr_L_out = rdwr_out_q;
  assign reg_addr_out    = addr_out_q;
  assign reg_data_out    = data_out_q;
  assign reg_src_out     = src_out_q;

endmodule
